pong_motion: RTL

Synchronous game-state engine for the 8-bit pong display. Owns ball position and direction, left paddle position, score and serve/miss sequencing, and updates them once per video frame on the vsync rising edge. Sits directly upstream of the pixel/video-output stage, which consumes `ball_hpos`, `ball_vpos` and `paddle_vpos` for drawing. Runs on the same clock as `hvsync_generator`.

---
 rtl/pong_motion_pkg.sv | 36 +++
 rtl/pong_motion_debouncer.sv | 44 ++++
 rtl/pong_motion.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/pong_motion_pkg.sv
// Shared types and defaults for the pong game-state engine and its pixel stage.
package pong_motion_pkg;

  localparam int POS_W   = 9;
  localparam int SCORE_W = 4;

  // Display and object-size defaults
  localparam int DISPLAY_WIDTH_DEF  = 256;
  localparam int DISPLAY_HEIGHT_DEF = 240;
  localparam int BALL_SIZE_DEF      = 4;
  localparam int BALL_SPEED_DEF     = 2;
  localparam int PADDLE_X_DEF       = 8;
  localparam int PADDLE_WIDTH_DEF   = 4;
  localparam int PADDLE_HEIGHT_DEF  = 32;
  localparam int PADDLE_SPEED_DEF   = 2;
  localparam int SERVE_FRAMES_DEF   = 30;
  localparam int MISS_FRAMES_DEF    = 60;

  // State encodings are shared with the pixel stage, so they are fixed values
  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_MISS  = 2'd2
  } state_e;

  // Direction bits: x is 1 when moving right, y is 1 when moving down
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pong_motion_debouncer.sv
// Button conditioner: 2-flop synchronizer followed by a stability counter.
// The output level follows the input only after it has disagreed with the
// current level for 2^BITS consecutive clocks.
module button_debouncer #(
  parameter int BITS = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic level_o
);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic [BITS-1:0] cnt_q, cnt_d;

  // Synchronizer, counter and debounced level registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // Count while the synced input disagrees; any agreement restarts the count
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (&cnt_q) level_d = sync2_q;
      else        cnt_d   = cnt_q + BITS'(1);
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/pong_motion.sv
// Per-frame game-state engine: ball, paddle, score and serve/miss sequencing.
// State advances once per vsync rising edge; all outputs are registered.
module pong_motion
  import pong_motion_pkg::*;
#(
  parameter int DISPLAY_WIDTH  = DISPLAY_WIDTH_DEF,
  parameter int DISPLAY_HEIGHT = DISPLAY_HEIGHT_DEF,
  parameter int BALL_SIZE      = BALL_SIZE_DEF,
  parameter int BALL_SPEED     = BALL_SPEED_DEF,
  parameter int PADDLE_X       = PADDLE_X_DEF,
  parameter int PADDLE_WIDTH   = PADDLE_WIDTH_DEF,
  parameter int PADDLE_HEIGHT  = PADDLE_HEIGHT_DEF,
  parameter int PADDLE_SPEED   = PADDLE_SPEED_DEF,
  parameter int SERVE_FRAMES   = SERVE_FRAMES_DEF,
  parameter int MISS_FRAMES    = MISS_FRAMES_DEF,
  parameter int DEBOUNCE_BITS  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vsync,
  input  logic               btn_up,
  input  logic               btn_down,
  output logic [POS_W-1:0]   ball_hpos,
  output logic [POS_W-1:0]   ball_vpos,
  output logic [POS_W-1:0]   paddle_vpos,
  output logic [SCORE_W-1:0] score,
  output logic               ball_active,
  output logic               miss
);

  localparam int CNT_W = $clog2(max2(SERVE_FRAMES, MISS_FRAMES));

  localparam logic [POS_W-1:0] SPD     = POS_W'(BALL_SPEED);
  localparam logic [POS_W-1:0] BS      = POS_W'(BALL_SIZE);
  localparam logic [POS_W-1:0] PH      = POS_W'(PADDLE_HEIGHT);
  localparam logic [POS_W-1:0] PSPD    = POS_W'(PADDLE_SPEED);
  localparam logic [POS_W-1:0] FACE    = POS_W'(PADDLE_X + PADDLE_WIDTH);
  localparam logic [POS_W-1:0] H_MAX   = POS_W'(DISPLAY_WIDTH - BALL_SIZE);
  localparam logic [POS_W-1:0] V_MAX   = POS_W'(DISPLAY_HEIGHT - BALL_SIZE);
  localparam logic [POS_W-1:0] P_MAX   = POS_W'(DISPLAY_HEIGHT - PADDLE_HEIGHT);
  localparam logic [POS_W-1:0] CX      = POS_W'(DISPLAY_WIDTH / 2);
  localparam logic [POS_W-1:0] CY      = POS_W'(DISPLAY_HEIGHT / 2);
  localparam logic [POS_W-1:0] P_RST   = POS_W'((DISPLAY_HEIGHT - PADDLE_HEIGHT) / 2);
  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0] MISS_LAST  = CNT_W'(MISS_FRAMES - 1);

  logic up_db, dn_db;

  button_debouncer #(.BITS(DEBOUNCE_BITS)) u_db_up (
    .clk(clk), .reset(reset), .btn_i(btn_up), .level_o(up_db)
  );

  button_debouncer #(.BITS(DEBOUNCE_BITS)) u_db_dn (
    .clk(clk), .reset(reset), .btn_i(btn_down), .level_o(dn_db)
  );

  logic               vsync_q, tick_q, tick_d;
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [POS_W-1:0]   hpos_q, hpos_d, vpos_q, vpos_d, paddle_q, paddle_d;
  logic               dx_q, dx_d, dy_q, dy_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               active_q, active_d;
  logic               miss_q, miss_d;
  logic               overlap;

  // Rising-edge detect on vsync; the tick is registered so updates land two
  // edges after vsync is first seen high
  assign tick_d = vsync & ~vsync_q;

  // Ball vertically overlaps the paddle (uses pre-update positions)
  assign overlap = (vpos_q + BS > paddle_q) && (vpos_q < paddle_q + PH);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_q  <= 1'b0;
      tick_q   <= 1'b0;
      state_q  <= ST_SERVE;
      cnt_q    <= '0;
      hpos_q   <= CX;
      vpos_q   <= CY;
      dx_q     <= DIR_LEFT;
      dy_q     <= DIR_DOWN;
      paddle_q <= P_RST;
      score_q  <= '0;
      active_q <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      vsync_q  <= vsync;
      tick_q   <= tick_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hpos_q   <= hpos_d;
      vpos_q   <= vpos_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      paddle_q <= paddle_d;
      score_q  <= score_d;
      active_q <= active_d;
      miss_q   <= miss_d;
    end
  end

  // Per-frame next state: paddle always moves, ball follows the FSM.
  // Every subtraction is guarded by a compare so positions never wrap.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hpos_d   = hpos_q;
    vpos_d   = vpos_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    paddle_d = paddle_q;
    score_d  = score_q;
    miss_d   = 1'b0;

    if (tick_q) begin
      if (up_db && !dn_db)
        paddle_d = (paddle_q < PSPD) ? '0 : paddle_q - PSPD;
      else if (dn_db && !up_db)
        paddle_d = (paddle_q >= P_MAX - PSPD) ? P_MAX : paddle_q + PSPD;

      case (state_q)
        ST_SERVE: begin
          hpos_d = CX;
          vpos_d = CY;
          if (cnt_q == SERVE_LAST) begin
            cnt_d   = '0;
            dx_d    = DIR_LEFT;
            dy_d    = DIR_DOWN;
            state_d = ST_PLAY;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        ST_PLAY: begin
          if (dx_q == DIR_LEFT) begin
            if (hpos_q < SPD) begin
              miss_d  = 1'b1;
              score_d = '0;
              state_d = ST_MISS;
            end else if (hpos_q >= FACE && hpos_q - SPD < FACE && overlap) begin
              hpos_d  = FACE;
              dx_d    = DIR_RIGHT;
              score_d = (&score_q) ? score_q : score_q + SCORE_W'(1);
            end else begin
              hpos_d = hpos_q - SPD;
            end
          end else begin
            if (hpos_q >= H_MAX - SPD) begin
              hpos_d = H_MAX;
              dx_d   = DIR_LEFT;
            end else begin
              hpos_d = hpos_q + SPD;
            end
          end

          // The whole ball freezes on the miss frame
          if (!miss_d) begin
            if (dy_q == DIR_UP) begin
              if (vpos_q < SPD) begin
                vpos_d = '0;
                dy_d   = DIR_DOWN;
              end else begin
                vpos_d = vpos_q - SPD;
              end
            end else begin
              if (vpos_q >= V_MAX - SPD) begin
                vpos_d = V_MAX;
                dy_d   = DIR_UP;
              end else begin
                vpos_d = vpos_q + SPD;
              end
            end
          end
        end

        ST_MISS: begin
          if (cnt_q == MISS_LAST) begin
            cnt_d   = '0;
            hpos_d  = CX;
            vpos_d  = CY;
            state_d = ST_SERVE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        default: begin
          cnt_d   = '0;
          state_d = ST_SERVE;
        end
      endcase
    end
  end

  // ball_active registered from the next state so it tracks PLAY exactly
  assign active_d = (state_d == ST_PLAY);

  assign ball_hpos   = hpos_q;
  assign ball_vpos   = vpos_q;
  assign paddle_vpos = paddle_q;
  assign score       = score_q;
  assign ball_active = active_q;
  assign miss        = miss_q;

endmodule
